// File: rtl/frame_buffer_ctrl.sv
// Frame-buffer controller for the undistort pipeline.
// It owns the single port of the frame BRAM. In FILL it packs camera pixels
// into BRAM words and writes one complete frame. In READY it gives the remap
// stage read-only access until that stage releases the frame.
//
// Pixel handshake: a pixel transfers on a rising edge where s_pix_valid and
// s_pix_ready are both 1. s_pix_sof is meaningful only on such a transfer.
// s_pix_ready does not depend on s_pix_valid. It is 1 in IDLE and FILL, and
// 0 in READY.
module frame_buffer_ctrl #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int PIX_WIDTH    = 8,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_WIDTH-1:0]  s_pix_data,
    input  logic                  s_pix_valid,
    input  logic                  s_pix_sof,
    output logic                  s_pix_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  frame_ready,
    input  logic                  frame_release,
    output logic                  sof_err,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [1:0]            dbg_state_o
);

    localparam int PPW         = DATA_WIDTH / PIX_WIDTH;
    localparam int FRAME_WORDS = FRAME_PIXELS / PPW;
    localparam int LANE_W      = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(PPW - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic                  bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                  sof_err_q, sof_err_d;
    logic                  s_pix_ready_q;
    logic                  frame_ready_q;
    logic                  rd_pend_q;
    logic                  rd_valid_q;

    logic                  pix_acc;
    logic                  take;
    logic                  rd_hit;
    logic [LANE_W-1:0]     lane_eff;
    logic [ADDR_WIDTH-1:0] wc_eff;

    // Next-state logic: FSM, pixel packing, word writes and read address capture.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_cnt_d  = word_cnt_q;
        pack_d      = pack_q;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        sof_err_d   = 1'b0;
        take        = 1'b0;
        lane_eff    = '0;
        wc_eff      = '0;
        pix_acc     = s_pix_valid && s_pix_ready_q;

        case (state_q)
            ST_IDLE: begin
                // Pixels seen before a start of frame are accepted and dropped.
                if (pix_acc && s_pix_sof) begin
                    take = 1'b1;
                end
            end
            ST_FILL: begin
                if (pix_acc) begin
                    take = 1'b1;
                    if (s_pix_sof) begin
                        // Restart the frame. The partial word is discarded.
                        sof_err_d = 1'b1;
                    end else begin
                        lane_eff = lane_q;
                        wc_eff   = word_cnt_q;
                    end
                end
            end
            ST_READY: begin
                if (frame_ready_q && frame_release) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            for (int i = 0; i < PPW; i++) begin
                if (lane_eff == LANE_W'(i)) begin
                    pack_d[i*PIX_WIDTH +: PIX_WIDTH] = s_pix_data;
                end
            end
            if (lane_eff == LAST_LANE) begin
                bram_we_d   = 1'b1;
                bram_addr_d = wc_eff;
                bram_din_d  = pack_d;
                lane_d      = '0;
                if (wc_eff == LAST_WORD) begin
                    // The counter stops at the last word, so it never wraps.
                    word_cnt_d = wc_eff;
                    state_d    = ST_READY;
                end else begin
                    word_cnt_d = wc_eff + ADDR_WIDTH'(1);
                    state_d    = ST_FILL;
                end
            end else begin
                lane_d     = lane_eff + LANE_W'(1);
                word_cnt_d = wc_eff;
                state_d    = ST_FILL;
            end
        end

        // Reads start only after the last write has landed (frame_ready high).
        // A read in the same cycle as a release is still honoured.
        rd_hit = (state_q == ST_READY) && frame_ready_q && rd_req;
        if (rd_hit) begin
            bram_addr_d = rd_addr;
        end
    end

    // State and output registers with a synchronous, active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            lane_q        <= '0;
            word_cnt_q    <= '0;
            pack_q        <= '0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            sof_err_q     <= 1'b0;
            s_pix_ready_q <= 1'b1;
            frame_ready_q <= 1'b0;
            rd_pend_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            word_cnt_q    <= word_cnt_d;
            pack_q        <= pack_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            sof_err_q     <= sof_err_d;
            s_pix_ready_q <= (state_d != ST_READY);
            frame_ready_q <= (state_q == ST_READY) && !(frame_ready_q && frame_release);
            rd_pend_q     <= rd_hit;
            rd_valid_q    <= rd_pend_q;
        end
    end

    assign s_pix_ready = s_pix_ready_q;
    assign frame_ready = frame_ready_q;
    assign sof_err     = sof_err_q;
    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = bram_dout;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: small frames (16 pixels, 4 words), a BRAM
// model, a pixel-stream reference model and logs of writes and reads.
module tb_frame_buffer_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int PW  = 8;
    localparam int FP  = 16;
    localparam int PPW = DW / PW;
    localparam int FW  = FP / PPW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] s_pix_data = '0;
    logic          s_pix_valid = 1'b0;
    logic          s_pix_sof = 1'b0;
    logic          s_pix_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_ready;
    logic          frame_release = 1'b0;
    logic          sof_err;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    frame_buffer_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_WIDTH(PW), .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk), .rst(rst),
        .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_sof(s_pix_sof),
        .s_pix_ready(s_pix_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_ready(frame_ready), .frame_release(frame_release), .sof_err(sof_err),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .dbg_state_o(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // BRAM model: read-first, one cycle read latency
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    // Monitor: logs writes, sof_err pulses and read returns with their cycle index
    logic [AW+DW-1:0] act_w_q[$];
    int               act_rd_cyc[$];
    logic [DW-1:0]    act_rd_dat[$];
    int               sof_err_cnt = 0;
    always @(posedge clk) begin
        if (bram_we) act_w_q.push_back({bram_addr, bram_din});
        if (sof_err) sof_err_cnt++;
        if (rd_valid) begin
            act_rd_cyc.push_back(cyc);
            act_rd_dat.push_back(rd_data);
        end
        cyc <= cyc + 1;
    end

    // Reference model: frame assembly from the accepted pixel stream
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    exp_mem [0:FW-1];
    logic [PW-1:0]    m_cur[$];
    bit               m_active = 0;
    int               m_words = 0;
    int               exp_sof_err = 0;
    int               exp_rd_cyc[$];
    int               exp_rd_addr[$];

    task automatic model_pixel(input logic [PW-1:0] p, input bit sof);
        logic [DW-1:0] word;
        if (sof) begin
            if (m_active) exp_sof_err++;
            m_active = 1;
            m_cur.delete();
            m_words = 0;
        end
        if (!m_active) return;
        m_cur.push_back(p);
        if (m_cur.size() == PPW) begin
            word = '0;
            for (int i = 0; i < PPW; i++) word[i*PW +: PW] = m_cur[i];
            exp_q.push_back({AW'(m_words), word});
            exp_mem[m_words] = word;
            m_words++;
            m_cur.delete();
            if (m_words == FW) m_active = 0;
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_cur.delete();
        m_words = 0;
    endtask

    task automatic clear_logs();
        act_w_q.delete();
        exp_q.delete();
        act_rd_cyc.delete();
        act_rd_dat.delete();
        exp_rd_cyc.delete();
        exp_rd_addr.delete();
        sof_err_cnt = 0;
        exp_sof_err = 0;
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [PW-1:0] p, input bit sof, input int max_gap);
        s_pix_data  = p;
        s_pix_sof   = sof;
        s_pix_valid = 1'b1;
        checks++;
        if (s_pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL pix_ready actual=%0b required=1", s_pix_ready);
        end
        tick();
        model_pixel(p, sof);
        s_pix_valid = 1'b0;
        s_pix_sof   = 1'b0;
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 20 && frame_ready !== 1'b1; n++) tick();
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        tick();
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks += 7;
        if (bram_we !== 1'b0) begin failures++; $display("FAIL rst_we actual=%0b required=0", bram_we); end
        if (bram_addr !== '0) begin failures++; $display("FAIL rst_addr actual=%0h required=0", bram_addr); end
        if (bram_din !== '0) begin failures++; $display("FAIL rst_din actual=%0h required=0", bram_din); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid actual=%0b required=0", rd_valid); end
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL rst_frame_ready actual=%0b required=0", frame_ready); end
        if (sof_err !== 1'b0) begin failures++; $display("FAIL rst_sof_err actual=%0b required=0", sof_err); end
        if (s_pix_ready !== 1'b1) begin failures++; $display("FAIL rst_pix_ready actual=%0b required=1", s_pix_ready); end
        rst = 1'b1;
        model_reset();
        clear_logs();
        tick();
    endtask

    task automatic test_fill(input bit junk);
        clear_logs();
        if (junk) for (int i = 0; i < 5; i++) send_pix(8'hAA, 1'b0, 0);
        for (int i = 0; i < FP; i++) send_pix(PW'(i), i == 0, 0);
        wait_ready();
        checks += 4;
        if (frame_ready !== 1'b1) begin failures++; $display("FAIL fill_frame_ready actual=%0b required=1", frame_ready); end
        if (s_pix_ready !== 1'b0) begin failures++; $display("FAIL fill_pix_ready actual=%0b required=0", s_pix_ready); end
        if (act_w_q.size() != FW) begin failures++; $display("FAIL fill_we_count actual=%0d required=%0d", act_w_q.size(), FW); end
        if (sof_err_cnt != 0) begin failures++; $display("FAIL fill_sof_err actual=%0d required=0", sof_err_cnt); end
        for (int i = 0; i < exp_q.size() && i < act_w_q.size(); i++) begin
            checks++;
            if (act_w_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL fill_write[%0d] actual=%h required=%h", i, act_w_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_read_pipeline();
        int addrs[3] = '{3, 0, 2};
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            rd_req  = 1'b1;
            rd_addr = AW'(addrs[i]);
            exp_rd_cyc.push_back(cyc + 2);
            exp_rd_addr.push_back(addrs[i]);
            tick();
        end
        rd_req = 1'b0;
        repeat (4) tick();
        checks += 2;
        if (act_rd_cyc.size() != 3) begin failures++; $display("FAIL rdpipe_count actual=%0d required=3", act_rd_cyc.size()); end
        if (act_w_q.size() != 0) begin failures++; $display("FAIL rdpipe_no_write actual=%0d required=0", act_w_q.size()); end
        for (int i = 0; i < 3 && i < act_rd_cyc.size(); i++) begin
            checks += 2;
            if (act_rd_cyc[i] != exp_rd_cyc[i]) begin
                failures++;
                $display("FAIL rdpipe_cycle[%0d] actual=%0d required=%0d", i, act_rd_cyc[i], exp_rd_cyc[i]);
            end
            if (act_rd_dat[i] !== exp_mem[exp_rd_addr[i]]) begin
                failures++;
                $display("FAIL rdpipe_data[%0d] actual=%h required=%h", i, act_rd_dat[i], exp_mem[exp_rd_addr[i]]);
            end
        end
    endtask

    task automatic test_release_collision();
        int req_cyc;
        clear_logs();
        rd_req = 1'b1;
        rd_addr = AW'(1);
        frame_release = 1'b1;
        req_cyc = cyc;
        tick();
        rd_req = 1'b0;
        frame_release = 1'b0;
        checks += 2;
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL rel_frame_ready actual=%0b required=0", frame_ready); end
        if (s_pix_ready !== 1'b1) begin failures++; $display("FAIL rel_pix_ready actual=%0b required=1", s_pix_ready); end
        repeat (3) tick();
        checks++;
        if (act_rd_cyc.size() != 1) begin
            failures++;
            $display("FAIL rel_rd_count actual=%0d required=1", act_rd_cyc.size());
        end else begin
            checks += 2;
            if (act_rd_cyc[0] != req_cyc + 2) begin failures++; $display("FAIL rel_rd_cycle actual=%0d required=%0d", act_rd_cyc[0], req_cyc + 2); end
            if (act_rd_dat[0] !== exp_mem[1]) begin failures++; $display("FAIL rel_rd_data actual=%h required=%h", act_rd_dat[0], exp_mem[1]); end
        end
        clear_logs();
        rd_req = 1'b1;
        rd_addr = AW'(2);
        tick();
        rd_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (act_rd_cyc.size() != 0) begin failures++; $display("FAIL idle_rd_ignored actual=%0d required=0", act_rd_cyc.size()); end
    endtask

    task automatic test_mid_sof();
        clear_logs();
        for (int i = 0; i < 6; i++) send_pix(PW'($urandom_range(0, 255)), i == 0, 0);
        for (int i = 0; i < FP; i++) send_pix(PW'(8'h10 + i), i == 0, 0);
        wait_ready();
        checks += 3;
        if (frame_ready !== 1'b1) begin failures++; $display("FAIL midsof_frame_ready actual=%0b required=1", frame_ready); end
        if (sof_err_cnt != 1) begin failures++; $display("FAIL midsof_sof_err actual=%0d required=1", sof_err_cnt); end
        if (act_w_q.size() != exp_q.size()) begin failures++; $display("FAIL midsof_we_count actual=%0d required=%0d", act_w_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_w_q.size(); i++) begin
            checks++;
            if (act_w_q[i] !== exp_q[i]) begin failures++; $display("FAIL midsof_write[%0d] actual=%h required=%h", i, act_w_q[i], exp_q[i]); end
        end
        for (int a = 0; a < FW; a++) begin
            checks++;
            if (mem[a] !== exp_mem[a]) begin failures++; $display("FAIL midsof_mem[%0d] actual=%h required=%h", a, mem[a], exp_mem[a]); end
        end
    endtask

    task automatic test_reset_mid_fill();
        clear_logs();
        for (int i = 0; i < 9; i++) send_pix(PW'($urandom_range(0, 255)), i == 0, 0);
        rst = 1'b0;
        tick();
        checks += 5;
        if (bram_we !== 1'b0) begin failures++; $display("FAIL rstfill_we actual=%0b required=0", bram_we); end
        if (bram_addr !== '0) begin failures++; $display("FAIL rstfill_addr actual=%0h required=0", bram_addr); end
        if (bram_din !== '0) begin failures++; $display("FAIL rstfill_din actual=%0h required=0", bram_din); end
        if (frame_ready !== 1'b0) begin failures++; $display("FAIL rstfill_frame_ready actual=%0b required=0", frame_ready); end
        if (s_pix_ready !== 1'b1) begin failures++; $display("FAIL rstfill_pix_ready actual=%0b required=1", s_pix_ready); end
        rst = 1'b1;
        model_reset();
        tick();
        for (int i = 0; i < FP; i++) send_pix(PW'($urandom_range(0, 255)), i == 0, 2);
        wait_ready();
        checks += 2;
        if (frame_ready !== 1'b1) begin failures++; $display("FAIL rstfill_frame_ready2 actual=%0b required=1", frame_ready); end
        if (act_w_q.size() != exp_q.size()) begin failures++; $display("FAIL rstfill_we_count actual=%0d required=%0d", act_w_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_w_q.size(); i++) begin
            checks++;
            if (act_w_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstfill_write[%0d] actual=%h required=%h", i, act_w_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int restart_at;
        for (int it = 0; it < 3; it++) begin
            clear_logs();
            restart_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : -1;
            for (int i = 0; i < restart_at; i++) send_pix(PW'($urandom_range(0, 255)), i == 0, 2);
            for (int i = 0; i < FP; i++) send_pix(PW'($urandom_range(0, 255)), i == 0, 2);
            wait_ready();
            checks += 3;
            if (frame_ready !== 1'b1) begin failures++; $display("FAIL rand_frame_ready actual=%0b required=1", frame_ready); end
            if (sof_err_cnt != exp_sof_err) begin failures++; $display("FAIL rand_sof_err actual=%0d required=%0d", sof_err_cnt, exp_sof_err); end
            if (act_w_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_we_count actual=%0d required=%0d", act_w_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < act_w_q.size(); i++) begin
                checks++;
                if (act_w_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_write[%0d] actual=%h required=%h", i, act_w_q[i], exp_q[i]); end
            end
            clear_logs();
            for (int j = 0; j < 10; j++) begin
                rd_req  = $urandom_range(0, 1) == 1;
                rd_addr = AW'($urandom_range(0, FW + 3));
                if (rd_req) begin
                    exp_rd_cyc.push_back(cyc + 2);
                    exp_rd_addr.push_back(int'(rd_addr));
                end
                tick();
            end
            rd_req = 1'b0;
            repeat (4) tick();
            checks++;
            if (act_rd_cyc.size() != exp_rd_cyc.size()) begin failures++; $display("FAIL rand_rd_count actual=%0d required=%0d", act_rd_cyc.size(), exp_rd_cyc.size()); end
            for (int i = 0; i < exp_rd_cyc.size() && i < act_rd_cyc.size(); i++) begin
                checks++;
                if (act_rd_cyc[i] != exp_rd_cyc[i]) begin failures++; $display("FAIL rand_rd_cycle[%0d] actual=%0d required=%0d", i, act_rd_cyc[i], exp_rd_cyc[i]); end
                if (exp_rd_addr[i] < FW) begin
                    checks++;
                    if (act_rd_dat[i] !== exp_mem[exp_rd_addr[i]]) begin
                        failures++;
                        $display("FAIL rand_rd_data[%0d] actual=%h required=%h", i, act_rd_dat[i], exp_mem[exp_rd_addr[i]]);
                    end
                end
            end
            release_frame();
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_fill(1'b0);
        test_read_pipeline();
        test_release_collision();
        test_fill(1'b1);
        release_frame();
        test_mid_sof();
        release_frame();
        test_reset_mid_fill();
        release_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
